// File: rtl/segre_csr_ctrl.sv
// CSR instruction sequencer: runs CSRRW/CSRRS/CSRRC as read-modify-write on the CSR file
// and arbitrates its single write port between the pipeline and hardware updaters.
module segre_csr_ctrl #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [1:0]        req_op_i,
    input  logic [ADDR_W-1:0] req_addr_i,
    input  logic [DATA_W-1:0] req_src_i,
    input  logic              req_src_zero_i,
    output logic              rsp_valid_o,
    output logic [DATA_W-1:0] rsp_rdata_o,
    output logic              rsp_err_o,
    input  logic              hw_valid_i,
    output logic              hw_ready_o,
    input  logic [ADDR_W-1:0] hw_addr_i,
    input  logic [DATA_W-1:0] hw_data_i,
    output logic [ADDR_W-1:0] csr_raddr_o,
    input  logic [DATA_W-1:0] csr_rdata_i,
    output logic              csr_we_o,
    output logic [ADDR_W-1:0] csr_waddr_o,
    output logic [DATA_W-1:0] csr_wdata_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    state_t              state_r, state_nxt_s;
    logic [1:0]          op_r;
    logic [ADDR_W-1:0]   addr_r;
    logic [DATA_W-1:0]   src_r;
    logic                src_zero_r;
    logic [DATA_W-1:0]   old_r;
    logic                prio_r;

    logic                req_grant_s;
    logic                hw_grant_s;
    logic                wr_intent_s;
    logic                err_s;
    logic [DATA_W-1:0]   new_s;

    function automatic logic [DATA_W-1:0] rmw_value(input logic [1:0] op,
                                                    input logic [DATA_W-1:0] old,
                                                    input logic [DATA_W-1:0] src);
        logic [DATA_W-1:0] res;
        case (op)
            2'b01:   res = src;
            2'b10:   res = old | src;
            2'b11:   res = old & ~src;
            default: res = {DATA_W{1'b0}};
        endcase
        return res;
    endfunction

    assign csr_raddr_o = addr_r;

    // Write intent and legality of the latched op; set/clear with a zero source is a pure read
    always_comb begin
        wr_intent_s = 1'b0;
        err_s       = 1'b0;
        if (op_r == 2'b00) begin
            err_s = 1'b1;
        end else begin
            wr_intent_s = !((op_r != 2'b01) && src_zero_r);
            err_s       = wr_intent_s && (addr_r[ADDR_W-1 -: 2] == 2'b11);
        end
        new_s = rmw_value(op_r, old_r, src_r);
    end

    // Next state, arbitration and CSR-file port drive; everything is held quiet while in reset
    always_comb begin
        state_nxt_s = state_r;
        req_ready_o = 1'b0;
        hw_ready_o  = 1'b0;
        rsp_valid_o = 1'b0;
        rsp_rdata_o = {DATA_W{1'b0}};
        rsp_err_o   = 1'b0;
        csr_we_o    = 1'b0;
        csr_waddr_o = {ADDR_W{1'b0}};
        csr_wdata_o = {DATA_W{1'b0}};
        req_grant_s = 1'b0;
        hw_grant_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!rst_i) begin
                    req_ready_o = !(hw_valid_i && !prio_r);
                    hw_ready_o  = hw_valid_i && !(req_valid_i && prio_r);
                    hw_grant_s  = hw_ready_o;
                    req_grant_s = req_valid_i && req_ready_o;
                    if (hw_grant_s) begin
                        csr_we_o    = 1'b1;
                        csr_waddr_o = hw_addr_i;
                        csr_wdata_o = hw_data_i;
                    end else begin
                        csr_we_o = 1'b0;
                    end
                    if (req_grant_s) begin
                        state_nxt_s = ST_READ;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_READ: begin
                state_nxt_s = ST_WRITE;
            end
            ST_WRITE: begin
                state_nxt_s = ST_IDLE;
                if (!rst_i) begin
                    rsp_valid_o = 1'b1;
                    rsp_rdata_o = old_r;
                    rsp_err_o   = err_s;
                    if (wr_intent_s && !err_s) begin
                        csr_we_o    = 1'b1;
                        csr_waddr_o = addr_r;
                        csr_wdata_o = new_s;
                    end else begin
                        csr_we_o = 1'b0;
                    end
                end else begin
                    rsp_valid_o = 1'b0;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, request latches, old-value capture and fairness flag
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r    <= ST_IDLE;
            op_r       <= 2'b00;
            addr_r     <= {ADDR_W{1'b0}};
            src_r      <= {DATA_W{1'b0}};
            src_zero_r <= 1'b0;
            old_r      <= {DATA_W{1'b0}};
            prio_r     <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if (req_grant_s) begin
                op_r       <= req_op_i;
                addr_r     <= req_addr_i;
                src_r      <= req_src_i;
                src_zero_r <= req_src_zero_i;
            end
            if (state_r == ST_READ) begin
                old_r <= csr_rdata_i;
            end
            // A hw write that overtook a waiting request hands the next slot to the pipeline
            if (req_grant_s) begin
                prio_r <= 1'b0;
            end else if (hw_grant_s && req_valid_i) begin
                prio_r <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_segre_csr_ctrl.sv
// Directed bench for segre_csr_ctrl with a behavioural CSR file attached.
module tb_segre_csr_ctrl;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [1:0]  req_op_i;
    logic [11:0] req_addr_i;
    logic [31:0] req_src_i;
    logic        req_src_zero_i;
    logic        rsp_valid_o;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic        hw_valid_i;
    logic        hw_ready_o;
    logic [11:0] hw_addr_i;
    logic [31:0] hw_data_i;
    logic [11:0] csr_raddr_o;
    logic [31:0] csr_rdata_i;
    logic        csr_we_o;
    logic [11:0] csr_waddr_o;
    logic [31:0] csr_wdata_o;

    logic [31:0] mem [0:4095];
    logic        bd_we;
    logic [11:0] bd_addr;
    logic [31:0] bd_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    segre_csr_ctrl #(.ADDR_W(12), .DATA_W(32)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
        .req_addr_i(req_addr_i), .req_src_i(req_src_i), .req_src_zero_i(req_src_zero_i),
        .rsp_valid_o(rsp_valid_o), .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o),
        .hw_valid_i(hw_valid_i), .hw_ready_o(hw_ready_o), .hw_addr_i(hw_addr_i),
        .hw_data_i(hw_data_i), .csr_raddr_o(csr_raddr_o), .csr_rdata_i(csr_rdata_i),
        .csr_we_o(csr_we_o), .csr_waddr_o(csr_waddr_o), .csr_wdata_o(csr_wdata_o)
    );

    // Behavioural CSR file: combinational read, posedge write, plus a preload port
    assign csr_rdata_i = mem[csr_raddr_o];
    always @(posedge clk) begin
        if (bd_we) mem[bd_addr] <= bd_data;
        else if (csr_we_o) mem[csr_waddr_o] <= csr_wdata_o;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic preload(input logic [11:0] a, input logic [31:0] d);
        bd_we = 1'b1; bd_addr = a; bd_data = d;
        tick();
        bd_we = 1'b0;
    endtask

    // Full pipeline op with no hw traffic: accept, READ, WRITE, back to IDLE
    task automatic do_op(input string tag, input logic [1:0] op, input logic [11:0] a,
                         input logic [31:0] src, input logic zero, input logic [31:0] exp_old,
                         input logic exp_err, input logic exp_we, input logic [31:0] exp_wdata);
        req_valid_i = 1'b1; req_op_i = op; req_addr_i = a; req_src_i = src; req_src_zero_i = zero;
        #1;
        chk({tag, "_ready"}, {31'd0, req_ready_o}, 32'd1);
        tick();
        req_valid_i = 1'b0;
        #1;
        chk({tag, "_read_quiet"}, {30'd0, rsp_valid_o, csr_we_o}, 32'd0);
        chk({tag, "_raddr"}, {20'd0, csr_raddr_o}, {20'd0, a});
        tick();
        #1;
        chk({tag, "_rsp_valid"}, {31'd0, rsp_valid_o}, 32'd1);
        chk({tag, "_rdata"}, rsp_rdata_o, exp_old);
        chk({tag, "_err"}, {31'd0, rsp_err_o}, {31'd0, exp_err});
        chk({tag, "_we"}, {31'd0, csr_we_o}, {31'd0, exp_we});
        chk({tag, "_waddr"}, {20'd0, csr_waddr_o}, exp_we ? {20'd0, a} : 32'd0);
        chk({tag, "_wdata"}, csr_wdata_o, exp_we ? exp_wdata : 32'd0);
        tick();
        #1;
        chk({tag, "_done"}, {31'd0, rsp_valid_o}, 32'd0);
    endtask

    initial begin
        rst_i = 1'b1; req_valid_i = 1'b0; req_op_i = 2'b00; req_addr_i = 12'h000;
        req_src_i = 32'h0; req_src_zero_i = 1'b0; hw_valid_i = 1'b0; hw_addr_i = 12'h000;
        hw_data_i = 32'h0; bd_we = 1'b0; bd_addr = 12'h000; bd_data = 32'h0;
        @(negedge clk);
        preload(12'h340, 32'hAAAA_0000);
        preload(12'h300, 32'h0000_000F);
        preload(12'hC00, 32'h00C0_FFEE);
        preload(12'h341, 32'h0000_0000);
        preload(12'h342, 32'h0000_0000);
        rst_i = 1'b0;
        #1;
        chk("rst_rsp_valid", {31'd0, rsp_valid_o}, 32'd0);
        chk("rst_rdata", rsp_rdata_o, 32'd0);
        chk("rst_err", {31'd0, rsp_err_o}, 32'd0);
        chk("rst_we", {31'd0, csr_we_o}, 32'd0);
        chk("rst_raddr", {20'd0, csr_raddr_o}, 32'd0);
        chk("rst_req_ready", {31'd0, req_ready_o}, 32'd1);
        chk("rst_hw_ready", {31'd0, hw_ready_o}, 32'd0);
        tick();

        do_op("rw340", 2'b01, 12'h340, 32'h0000_1234, 1'b0, 32'hAAAA_0000, 1'b0, 1'b1, 32'h0000_1234);
        chk("rw340_mem", mem[12'h340], 32'h0000_1234);
        chk("idle_raddr_hold", {20'd0, csr_raddr_o}, 32'h340);
        do_op("rs300", 2'b10, 12'h300, 32'h0000_00F0, 1'b0, 32'h0000_000F, 1'b0, 1'b1, 32'h0000_00FF);
        do_op("rc300", 2'b11, 12'h300, 32'h0000_000F, 1'b0, 32'h0000_00FF, 1'b0, 1'b1, 32'h0000_00F0);
        do_op("rs_zero", 2'b10, 12'h300, 32'h0000_0000, 1'b1, 32'h0000_00F0, 1'b0, 1'b0, 32'h0);
        chk("rs_zero_mem", mem[12'h300], 32'h0000_00F0);
        do_op("rw_ro", 2'b01, 12'hC00, 32'h0000_0001, 1'b0, 32'h00C0_FFEE, 1'b1, 1'b0, 32'h0);
        chk("rw_ro_mem", mem[12'hC00], 32'h00C0_FFEE);
        do_op("op00", 2'b00, 12'h300, 32'h0000_0055, 1'b0, 32'h0000_00F0, 1'b1, 1'b0, 32'h0);
        chk("op00_mem", mem[12'h300], 32'h0000_00F0);
        do_op("rc_ro_zero", 2'b11, 12'hC00, 32'h0000_0000, 1'b1, 32'h00C0_FFEE, 1'b0, 1'b0, 32'h0);

        // Arbitration: both valid in IDLE, hw first, then the request
        hw_valid_i = 1'b1; hw_addr_i = 12'h341; hw_data_i = 32'h0000_0055;
        req_valid_i = 1'b1; req_op_i = 2'b01; req_addr_i = 12'h340; req_src_i = 32'h0000_9999;
        req_src_zero_i = 1'b0;
        #1;
        chk("arb1_hw_ready", {31'd0, hw_ready_o}, 32'd1);
        chk("arb1_req_ready", {31'd0, req_ready_o}, 32'd0);
        chk("arb1_we", {31'd0, csr_we_o}, 32'd1);
        chk("arb1_waddr", {20'd0, csr_waddr_o}, 32'h341);
        chk("arb1_wdata", csr_wdata_o, 32'h0000_0055);
        tick();
        #1;
        chk("arb2_hw_ready", {31'd0, hw_ready_o}, 32'd0);
        chk("arb2_req_ready", {31'd0, req_ready_o}, 32'd1);
        chk("arb2_we", {31'd0, csr_we_o}, 32'd0);
        chk("arb2_mem341", mem[12'h341], 32'h0000_0055);
        tick();
        req_valid_i = 1'b0; hw_data_i = 32'h0000_0066;
        #1;
        chk("arb_read_hw_ready", {31'd0, hw_ready_o}, 32'd0);
        chk("arb_read_we", {31'd0, csr_we_o}, 32'd0);
        tick();
        #1;
        chk("arb_wr_hw_ready", {31'd0, hw_ready_o}, 32'd0);
        chk("arb_wr_rsp", {31'd0, rsp_valid_o}, 32'd1);
        chk("arb_wr_rdata", rsp_rdata_o, 32'h0000_1234);
        chk("arb_wr_waddr", {20'd0, csr_waddr_o}, 32'h340);
        chk("arb_wr_wdata", csr_wdata_o, 32'h0000_9999);
        tick();
        #1;
        chk("arb_hw_late_ready", {31'd0, hw_ready_o}, 32'd1);
        chk("arb_hw_late_waddr", {20'd0, csr_waddr_o}, 32'h341);
        chk("arb_mem340", mem[12'h340], 32'h0000_9999);
        tick();
        hw_valid_i = 1'b0;
        #1;
        chk("arb_mem341_late", mem[12'h341], 32'h0000_0066);

        // hw request rising during READ waits for IDLE
        req_valid_i = 1'b1; req_op_i = 2'b10; req_addr_i = 12'h300; req_src_i = 32'h0000_0100;
        tick();
        req_valid_i = 1'b0; hw_valid_i = 1'b1; hw_addr_i = 12'h342; hw_data_i = 32'h0000_0077;
        #1;
        chk("hwop_read_ready", {31'd0, hw_ready_o}, 32'd0);
        tick();
        #1;
        chk("hwop_wr_ready", {31'd0, hw_ready_o}, 32'd0);
        chk("hwop_rdata", rsp_rdata_o, 32'h0000_00F0);
        chk("hwop_wdata", csr_wdata_o, 32'h0000_01F0);
        tick();
        #1;
        chk("hwop_idle_ready", {31'd0, hw_ready_o}, 32'd1);
        chk("hwop_idle_waddr", {20'd0, csr_waddr_o}, 32'h342);
        tick();
        hw_valid_i = 1'b0;
        #1;
        chk("hwop_mem342", mem[12'h342], 32'h0000_0077);
        chk("hwop_mem300", mem[12'h300], 32'h0000_01F0);

        // Reset asserted in WRITE aborts the op
        req_valid_i = 1'b1; req_op_i = 2'b01; req_addr_i = 12'h340; req_src_i = 32'h0000_DEAD;
        tick();
        req_valid_i = 1'b0;
        tick();
        rst_i = 1'b1;
        #1;
        chk("rstwr_we", {31'd0, csr_we_o}, 32'd0);
        chk("rstwr_rsp", {31'd0, rsp_valid_o}, 32'd0);
        tick();
        rst_i = 1'b0;
        #1;
        chk("rstwr_after_outs", {29'd0, rsp_valid_o, rsp_err_o, csr_we_o}, 32'd0);
        chk("rstwr_after_rdata", rsp_rdata_o, 32'd0);
        chk("rstwr_after_raddr", {20'd0, csr_raddr_o}, 32'd0);
        chk("rstwr_mem340", mem[12'h340], 32'h0000_9999);
        do_op("post_rst", 2'b01, 12'h340, 32'h0000_BEEF, 1'b0, 32'h0000_9999, 1'b0, 1'b1, 32'h0000_BEEF);
        chk("post_rst_mem", mem[12'h340], 32'h0000_BEEF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
